// File: rtl/stream_checker.sv
// stream_checker: stream sink with patterned backpressure, packet sequence checking and stall-stability monitoring
module stream_checker #(
    parameter int DataWidth  = 32,
    parameter int CountWidth = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DataWidth-1:0]  readData,
    input  logic                  readDataValid,
    input  logic                  readDataLast,
    output logic                  readDataReady,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [DataWidth-1:0]  packet_len,
    input  logic [DataWidth-1:0]  first_value,
    input  logic [7:0]            ready_pattern,
    output logic [CountWidth-1:0] beat_count,
    output logic [CountWidth-1:0] packet_count,
    output logic [CountWidth-1:0] error_count,
    output logic                  error_flag,
    output logic [DataWidth-1:0]  err_expected,
    output logic [DataWidth-1:0]  err_actual,
    output logic                  proto_error
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;
    logic [2:0] phase;
    logic run_q, synced, hs, last_exp, mismatch, stall, stall_last, violation;
    logic [DataWidth-1:0] exp_q, idx, exp_cur, idx_cur, len_m1, stall_data;

    // RUN follows enable one cycle late; the phase walks the ready pattern only while running
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            phase <= 3'd0;
        end else begin
            state <= state_next;
            phase <= run_q ? phase + 3'd1 : 3'd0;
        end
    end

    // Next state, ready, handshake and per-beat check decode; an unsynced tracker reads as the packet start
    always_comb begin
        state_next = enable ? RUN : IDLE;
        run_q = state == RUN;
        readDataReady = run_q & ready_pattern[phase];
        hs = readDataValid & readDataReady;
        exp_cur = synced ? exp_q : first_value;
        idx_cur = synced ? idx : '0;
        len_m1 = packet_len == '0 ? '0 : packet_len - DataWidth'(1);
        last_exp = idx_cur == len_m1;
        mismatch = (readData != exp_cur) | (readDataLast != last_exp);
        violation = stall & (~readDataValid | (readData != stall_data) | (readDataLast != stall_last));
    end

    // Tracking, counters and sticky flags; clear outranks a beat landing in the same cycle
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            synced <= 1'b0;
            exp_q <= first_value;
            idx <= '0;
            beat_count <= '0;
            packet_count <= '0;
            error_count <= '0;
            error_flag <= 1'b0;
            err_expected <= '0;
            err_actual <= '0;
            proto_error <= 1'b0;
        end else begin
            synced <= synced | run_q;
            exp_q <= hs ? (readDataLast ? first_value : exp_cur + DataWidth'(1)) : exp_cur;
            idx <= hs ? (readDataLast ? '0 : idx_cur + DataWidth'(idx_cur != '1)) : idx_cur;
            proto_error <= proto_error | violation;
            if (hs) begin
                beat_count <= beat_count + CountWidth'(beat_count != '1);
                packet_count <= packet_count + CountWidth'(readDataLast && packet_count != '1);
                error_count <= error_count + CountWidth'(mismatch && error_count != '1);
                if (mismatch && !error_flag) begin
                    error_flag <= 1'b1;
                    err_expected <= exp_cur;
                    err_actual <= readData;
                end
            end
        end
    end

    // Remember a stalled beat so the source can be held to it on the following cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            stall <= 1'b0;
            stall_data <= '0;
            stall_last <= 1'b0;
        end else begin
            stall <= readDataValid & ~readDataReady;
            stall_data <= readData;
            stall_last <= readDataLast;
        end
    end
endmodule

// File: tb/tb_stream_checker.sv
// tb_stream_checker: directed and randomized stimulus against a packet-level reference model
module tb_stream_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, readDataValid = 1'b0, readDataLast = 1'b0, enable = 1'b0, clear = 1'b0;
    logic [31:0] readData = '0, packet_len = 32'd16, first_value = '0;
    logic [7:0] ready_pattern = 8'hFF;
    logic readDataReady, error_flag, proto_error;
    logic [31:0] beat_count, packet_count, error_count, err_expected, err_actual;

    int tests = 0, fails = 0;
    bit checking = 1'b0;

    bit m_run, m_synced, m_err_flag, m_proto, m_prev_stall, m_prev_last;
    int m_k;
    logic [31:0] m_base, m_prev_data, m_err_exp, m_err_act, src_pos, plen_eff;
    longint m_pos, m_beats, m_pkts, m_errs;

    stream_checker #(.DataWidth(32), .CountWidth(32)) dut (
        .clk(clk), .reset(reset), .readData(readData), .readDataValid(readDataValid),
        .readDataLast(readDataLast), .readDataReady(readDataReady), .enable(enable), .clear(clear),
        .packet_len(packet_len), .first_value(first_value), .ready_pattern(ready_pattern),
        .beat_count(beat_count), .packet_count(packet_count), .error_count(error_count),
        .error_flag(error_flag), .err_expected(err_expected), .err_actual(err_actual),
        .proto_error(proto_error)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    // Ready is on in the k-th running cycle (k counted from 0 since enable took effect) when pattern bit k mod 8 is set
    function automatic bit m_ready();
        return m_run && ready_pattern[m_k[2:0]];
    endfunction

    // Advance the model across one clock edge using the inputs currently driven
    function automatic void model_update();
        bit rdy, hs, viol, bad;
        logic [31:0] base, e;
        longint pos, plen;
        rdy = m_ready();
        hs = readDataValid && rdy;
        if (reset) begin
            m_run = 0; m_k = 0; m_synced = 0; m_pos = 0; m_base = first_value;
            m_beats = 0; m_pkts = 0; m_errs = 0; m_err_flag = 0; m_err_exp = '0; m_err_act = '0;
            m_proto = 0; m_prev_stall = 0;
            return;
        end
        viol = m_prev_stall && (!readDataValid || readData != m_prev_data || readDataLast != m_prev_last);
        m_prev_stall = readDataValid && !rdy;
        m_prev_data = readData;
        m_prev_last = readDataLast;
        if (clear) begin
            m_beats = 0; m_pkts = 0; m_errs = 0; m_err_flag = 0; m_err_exp = '0; m_err_act = '0;
            m_proto = 0; m_synced = 0;
        end else begin
            if (viol) m_proto = 1;
            base = m_synced ? m_base : first_value;
            pos = m_synced ? m_pos : 0;
            if (hs) begin
                plen = (packet_len == 0) ? 1 : longint'(packet_len);
                e = base + pos[31:0];
                bad = (readData != e) || (readDataLast != (pos == plen - 1));
                m_beats++;
                if (readDataLast) m_pkts++;
                if (bad) begin
                    m_errs++;
                    if (!m_err_flag) begin
                        m_err_flag = 1; m_err_exp = e; m_err_act = readData;
                    end
                end
                if (readDataLast) begin
                    m_base = first_value; m_pos = 0;
                end else begin
                    m_base = base; m_pos = pos + 1;
                end
                m_synced = 1;
            end else if (m_run) begin
                m_base = base; m_pos = pos; m_synced = 1;
            end
        end
        m_k = m_run ? m_k + 1 : 0;
        m_run = enable;
    endfunction

    // Every cycle, all outputs against the model
    always @(negedge clk) begin
        if (checking) begin
            chk("ready", {31'b0, readDataReady}, {31'b0, m_ready()});
            chk("beat_count", beat_count, m_beats[31:0]);
            chk("packet_count", packet_count, m_pkts[31:0]);
            chk("error_count", error_count, m_errs[31:0]);
            chk("error_flag", {31'b0, error_flag}, {31'b0, m_err_flag});
            chk("err_expected", err_expected, m_err_exp);
            chk("err_actual", err_actual, m_err_act);
            chk("proto_error", {31'b0, proto_error}, {31'b0, m_proto});
        end
    end

    task automatic tick();
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; clear = 0; readDataValid = 0; readDataLast = 0;
        tick();
        checking = 1;
        tick();
        reset = 0;
    endtask

    task automatic send(input logic [31:0] d, input bit l);
        int guard = 0;
        readDataValid = 1; readData = d; readDataLast = l;
        while (!m_ready() && guard < 64) begin
            tick();
            guard++;
        end
        if (!m_ready()) begin
            tests++; fails++;
            $display("FAIL send_timeout: ready not seen within 64 cycles for data %h", d);
        end
        tick();
        readDataValid = 0;
    endtask

    initial begin
        @(negedge clk);
        #1;
        // Three clean packets at full rate
        packet_len = 16; first_value = 0; ready_pattern = 8'hFF;
        do_reset();
        enable = 1;
        for (int p = 0; p < 3; p++) for (int b = 0; b < 16; b++) send(32'(b), b == 15);
        chk("s1_beats", beat_count, 32'd48);
        chk("s1_packets", packet_count, 32'd3);
        chk("s1_errors", error_count, 32'd0);
        chk("s1_flag", {31'b0, error_flag}, 32'd0);
        // Alternating backpressure
        ready_pattern = 8'b0101_0101;
        do_reset();
        enable = 1;
        tick();
        chk("s2_ready_ph0", {31'b0, readDataReady}, 32'd1);
        tick();
        chk("s2_ready_ph1", {31'b0, readDataReady}, 32'd0);
        for (int p = 0; p < 3; p++) for (int b = 0; b < 16; b++) send(32'(b), b == 15);
        chk("s2_beats", beat_count, 32'd48);
        chk("s2_packets", packet_count, 32'd3);
        chk("s2_errors", error_count, 32'd0);
        chk("s2_proto", {31'b0, proto_error}, 32'd0);
        // Corrupted beat 5 of packet 1
        ready_pattern = 8'hFF;
        do_reset();
        enable = 1;
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 16; b++) send((p == 1 && b == 5) ? 32'hABCD_EFFF : 32'(b), b == 15);
        chk("s3_errors", error_count, 32'd1);
        chk("s3_err_expected", err_expected, 32'd5);
        chk("s3_err_actual", err_actual, 32'hABCD_EFFF);
        chk("s3_beats", beat_count, 32'd48);
        // Early last, then resync
        do_reset();
        enable = 1;
        for (int b = 0; b < 10; b++) send(32'(b), b == 9);
        for (int b = 0; b < 16; b++) send(32'(b), b == 15);
        chk("s4_errors", error_count, 32'd1);
        chk("s4_packets", packet_count, 32'd2);
        chk("s4_err_expected", err_expected, 32'd9);
        // Data changed while stalled
        ready_pattern = 8'hFC;
        do_reset();
        enable = 1;
        tick();
        readDataValid = 1; readData = 0; readDataLast = 0;
        tick();
        readData = 7;
        tick();
        chk("s5_proto", {31'b0, proto_error}, 32'd1);
        chk("s5_errors", error_count, 32'd0);
        readDataValid = 0;
        tick();
        // Wrap, enable pause, reset mid-packet
        ready_pattern = 8'hFF; packet_len = 4; first_value = 32'hFFFF_FFFE;
        do_reset();
        enable = 1;
        send(32'hFFFF_FFFE, 0);
        send(32'hFFFF_FFFF, 0);
        enable = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("s6_pause_ready", {31'b0, readDataReady}, 32'd0);
            tick();
        end
        enable = 1;
        send(32'h0, 0);
        send(32'h1, 1);
        chk("s6_errors", error_count, 32'd0);
        chk("s6_beats", beat_count, 32'd4);
        chk("s6_packets", packet_count, 32'd1);
        send(32'hFFFF_FFFE, 0);
        do_reset();
        chk("s6_rst_beats", beat_count, 32'd0);
        chk("s6_rst_ready", {31'b0, readDataReady}, 32'd0);
        enable = 1;
        send(32'hFFFF_FFFE, 0);
        chk("s6_restart_errors", error_count, 32'd0);
        chk("s6_restart_beats", beat_count, 32'd1);
        // Randomized traffic with occasional faults, clears and resets
        src_pos = 0;
        for (int c = 0; c < 4000; c++) begin
            clear = 0;
            if ($urandom_range(299) == 0) begin
                first_value = $urandom_range(1) ? 32'hFFFF_FFFD : $urandom;
                packet_len = $urandom_range(6);
                ready_pattern = 8'($urandom);
                src_pos = 0;
                do_reset();
                enable = 1;
            end else begin
                if (!m_prev_stall && $urandom_range(199) == 0) begin
                    clear = 1; readDataValid = 0; src_pos = 0;
                    packet_len = $urandom_range(6);
                end else begin
                    if ($urandom_range(19) == 0) enable = ~enable;
                    if ($urandom_range(49) == 0) ready_pattern = 8'($urandom);
                    if (m_prev_stall) begin
                        if ($urandom_range(99) == 0) begin
                            if ($urandom_range(1) == 1) readDataValid = 0;
                            else readData = readData ^ 32'h1;
                        end
                    end else begin
                        plen_eff = (packet_len == 0) ? 32'd1 : packet_len;
                        readDataValid = $urandom_range(3) != 0;
                        readData = first_value + src_pos;
                        readDataLast = src_pos >= plen_eff - 1;
                        if ($urandom_range(39) == 0) readData = readData ^ 32'h10;
                        if ($urandom_range(39) == 0) readDataLast = ~readDataLast;
                    end
                    if (readDataValid && m_ready()) src_pos = readDataLast ? 32'd0 : src_pos + 1;
                end
                tick();
            end
        end
        clear = 0;
        readDataValid = 0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
